// File: rtl/sdram_cpu_pkg.sv
// Shared types for the SDRAM channel A CPU front end: request record,
// sequencer states and the read value returned when the controller hangs.
package sdram_cpu_pkg;

    localparam int unsigned REQ_ADDR_W = 21;
    localparam logic [7:0]  TMO_FILL   = 8'hFF;

    typedef struct packed {
        logic                  we;
        logic [REQ_ADDR_W-1:0] addr;
        logic [7:0]            data;
    } req_t;

    typedef enum logic [2:0] {
        S_DRAIN,
        S_IDLE,
        S_ISSUE,
        S_ARM,
        S_WAIT,
        S_DONE
    } state_e;

endpackage

// File: rtl/sdram_cpu_port_if.sv
// CPU request bus plus the RAM_A_* controller port of SDRAM channel A.
// slave is the front end's view; master is the CPU glue / controller side.
interface sdram_cpu_port_if #(
    parameter int unsigned ADDR_W = 21
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_din;
    logic              cpu_ready;
    logic              cpu_rvalid;
    logic [7:0]        cpu_dout;
    logic              busy;
    logic              tmo_err;
    logic [ADDR_W-1:0] RAM_A_ADDR;
    logic              RAM_A_REQ;
    logic              RAM_A_RD_n;
    logic [7:0]        RAM_A_DI;
    logic [7:0]        RAM_A_DO;
    logic              RAM_A_WAIT;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_din, RAM_A_DO, RAM_A_WAIT,
        output cpu_ready, cpu_rvalid, cpu_dout, busy, tmo_err,
               RAM_A_ADDR, RAM_A_REQ, RAM_A_RD_n, RAM_A_DI
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_din, RAM_A_DO, RAM_A_WAIT,
        input  cpu_ready, cpu_rvalid, cpu_dout, busy, tmo_err,
               RAM_A_ADDR, RAM_A_REQ, RAM_A_RD_n, RAM_A_DI
    );

endinterface

// File: rtl/sdram_req_fifo.sv
// In-order request queue with a registered read port; the read register
// doubles as the issue register that drives the controller address/data.
module sdram_req_fifo
    import sdram_cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push_i,
    input  logic pop_i,
    input  req_t wdata_i,
    output req_t rdata_o,
    output logic full_o,
    output logic empty_o
);
    localparam int unsigned PW      = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);

    req_t        mem_q [DEPTH];
    req_t        rdata_q;
    logic [PW:0] wr_q;
    logic [PW:0] rd_q;
    logic        do_push;
    logic        do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = rdata_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[PW-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            rdata_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_q    <= rd_q + PTR_ONE;
                rdata_q <= mem_q[rd_q[PW-1:0]];
            end
        end
    end

endmodule

// File: rtl/sdram_cpu_port.sv
// CPU-side front end for SDRAM channel A: queues byte requests, issues them
// one at a time as RAM_A_REQ pulses and guards each access with a watchdog.
module sdram_cpu_port
    import sdram_cpu_pkg::*;
#(
    parameter int unsigned ADDR_W     = REQ_ADDR_W,
    parameter int unsigned QDEPTH     = 4,
    parameter int unsigned TMO_CYCLES = 255
) (
    input logic             clk,
    input logic             reset,
    sdram_cpu_port_if.slave bus
);
    localparam int unsigned WD_RAW  = $clog2(TMO_CYCLES + 1);
    localparam int unsigned WD_W    = (WD_RAW < 8) ? 8 : WD_RAW;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TMO_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    if (ADDR_W != REQ_ADDR_W) begin : g_addr_w_check
        $error("ADDR_W must equal the request record address width");
    end

    state_e          state_q, state_d;
    req_t            push_req;
    req_t            iss;
    logic            full, empty, push, pop;
    logic            timeout;
    logic            rd_out_q;
    logic            rvalid_q;
    logic [7:0]      dout_q;
    logic            tmo_q;
    logic            hit_tmo_q;
    logic [WD_W-1:0] wd_q;

    assign bus.cpu_ready = !full && !rd_out_q && (state_q != S_DRAIN);
    assign push          = bus.cpu_req && bus.cpu_ready;
    assign push_req      = '{we: bus.cpu_we, addr: bus.cpu_addr, data: bus.cpu_din};

    sdram_req_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_req),
        .rdata_o (iss),
        .full_o  (full),
        .empty_o (empty)
    );

    // The popped entry stays in the FIFO read register until the next pop,
    // which keeps ADDR/RD_n/DI stable for the whole access.
    assign bus.RAM_A_ADDR = iss.addr;
    assign bus.RAM_A_RD_n = iss.we;
    assign bus.RAM_A_DI   = iss.data;
    assign bus.RAM_A_REQ  = (state_q == S_ISSUE);
    assign bus.cpu_rvalid = rvalid_q;
    assign bus.cpu_dout   = dout_q;
    assign bus.tmo_err    = tmo_q;
    assign bus.busy       = !empty || ((state_q != S_IDLE) && (state_q != S_DRAIN));

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        timeout = 1'b0;
        case (state_q)
            S_DRAIN: if (!bus.RAM_A_WAIT) state_d = S_IDLE;
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_ARM;
            S_ARM, S_WAIT: begin
                if (!bus.RAM_A_WAIT) begin
                    state_d = S_DONE;
                end else if (wd_q == WD_LAST) begin
                    timeout = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_DRAIN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_DRAIN;
            rd_out_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            dout_q    <= '0;
            tmo_q     <= 1'b0;
            hit_tmo_q <= 1'b0;
            wd_q      <= '0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= (state_q == S_DONE) && !iss.we;
            if ((state_q == S_DONE) && !iss.we) begin
                dout_q <= hit_tmo_q ? TMO_FILL : bus.RAM_A_DO;
            end
            if (push && !bus.cpu_we) begin
                rd_out_q <= 1'b1;
            end else if (rvalid_q) begin
                rd_out_q <= 1'b0;
            end
            if (state_q == S_ISSUE) begin
                wd_q      <= '0;
                hit_tmo_q <= 1'b0;
            end else if ((state_q == S_ARM) || (state_q == S_WAIT)) begin
                wd_q <= wd_q + WD_ONE;
            end
            if (timeout) begin
                tmo_q     <= 1'b1;
                hit_tmo_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_cpu_port.sv
// Self-checking bench: controller model + transaction-level reference for
// sdram_cpu_port, with table vectors, directed corner cases and random traffic.
module tb_sdram_cpu_port;
    localparam int unsigned AW  = 21;
    localparam int unsigned QD  = 4;
    localparam int unsigned TMO = 40;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } txn_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    data;
        int            lat;
        logic [7:0]    exp_dout;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sdram_cpu_port_if #(.ADDR_W(AW)) bus ();

    sdram_cpu_port #(.ADDR_W(AW), .QDEPTH(QD), .TMO_CYCLES(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic       ram_wait = 1'b0;
    logic [7:0] ram_do   = 8'h00;
    assign bus.RAM_A_WAIT = ram_wait;
    assign bus.RAM_A_DO   = ram_do;

    int checks = 0;
    int errors = 0;

    // Controller model and reference state
    int            lat_fix  = 3;
    bit            lat_rand = 1'b0;
    bit            hang     = 1'b0;
    int            w_left   = 0;
    bit            stuck    = 1'b0;
    bit            track    = 1'b0;
    int            cyc      = 0;
    int            last_req = -100;
    int            n_done   = 0;
    txn_t          cap;
    txn_t          exp_iss[$];
    logic [7:0]    exp_rd[$];
    logic [7:0]    cmem    [logic [AW-1:0]];
    logic [7:0]    ref_mem [logic [AW-1:0]];
    vec_t          vecs[9];

    function automatic logic [7:0] dflt(input logic [AW-1:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic complete();
        if (cap.we) cmem[cap.addr] = cap.data;
        else ram_do = cmem.exists(cap.addr) ? cmem[cap.addr] : dflt(cap.addr);
        ram_wait = 1'b0;
        track    = 1'b0;
        n_done++;
    endtask

    task automatic model_loop();
        bit   was_busy;
        int   l;
        txn_t t;
        forever begin
            @(negedge clk);
            cyc++;
            was_busy = (w_left > 0) || stuck;
            if (reset) begin
                exp_iss.delete();
                exp_rd.delete();
                track = 1'b0;
            end else begin
                if (bus.cpu_req && bus.cpu_ready) begin
                    exp_iss.push_back(txn_t'{we: bus.cpu_we, addr: bus.cpu_addr, data: bus.cpu_din});
                    if (bus.cpu_we) ref_mem[bus.cpu_addr] = bus.cpu_din;
                    else if (hang) exp_rd.push_back(8'hFF);
                    else exp_rd.push_back(ref_mem.exists(bus.cpu_addr) ? ref_mem[bus.cpu_addr]
                                                                       : dflt(bus.cpu_addr));
                end
                if (bus.cpu_rvalid) begin
                    if (exp_rd.size() == 0) chk("rvalid_unexpected", 1, 0);
                    else chk("rd_data", bus.cpu_dout, exp_rd.pop_front());
                end
                if (track && was_busy) begin
                    chk("hold_rdn", bus.RAM_A_RD_n, cap.we);
                    chk("hold_addr", bus.RAM_A_ADDR, cap.addr);
                    chk("hold_di", bus.RAM_A_DI, cap.data);
                end
            end
            if (w_left > 0) begin
                w_left--;
                if (w_left == 0) complete();
            end else if (stuck && !hang) begin
                stuck    = 1'b0;
                ram_wait = 1'b0;
                track    = 1'b0;
            end
            if (bus.RAM_A_REQ) begin
                chk("req_while_wait", 32'((w_left > 0) || stuck), 0);
                chk("req_spacing", 32'((cyc - last_req) >= 2), 1);
                if (!reset) begin
                    if (exp_iss.size() == 0) chk("req_unexpected", 1, 0);
                    else begin
                        t = exp_iss.pop_front();
                        chk("req_rdn", bus.RAM_A_RD_n, t.we);
                        chk("req_addr", bus.RAM_A_ADDR, t.addr);
                        chk("req_di", bus.RAM_A_DI, t.data);
                    end
                end
                cap      = txn_t'{we: bus.RAM_A_RD_n, addr: bus.RAM_A_ADDR, data: bus.RAM_A_DI};
                track    = 1'b1;
                last_req = cyc;
                l = lat_rand ? int'($urandom_range(0, 5)) : lat_fix;
                if (hang) begin
                    stuck    = 1'b1;
                    ram_wait = 1'b1;
                end else if (l == 0) begin
                    complete();
                end else begin
                    w_left   = l;
                    ram_wait = 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic we, input logic [AW-1:0] a, input logic [7:0] d);
        int n = 0;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = we;
        bus.cpu_addr = a;
        bus.cpu_din  = d;
        while (!bus.cpu_ready && n < 500) begin
            tick();
            n++;
        end
        if (!bus.cpu_ready) chk("accept_timeout", 0, 1);
        tick();
        bus.cpu_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bus.busy || w_left > 0 || stuck) && n < 2000) begin
            tick();
            n++;
        end
        chk("idle_reached", 32'(bus.busy || w_left > 0 || stuck), 0);
    endtask

    task automatic wait_rvalid(input int lim, output int n);
        n = 0;
        while (!bus.cpu_rvalid && n < lim) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (!bus.RAM_A_REQ && n < 50) begin
            tick();
            n++;
        end
        chk("req_seen", bus.RAM_A_REQ, 1);
    endtask

    initial begin
        int acc, n, rv_idx, rdy_idx, base_done, early;
        logic [7:0] held;

        fork
            model_loop();
            begin
                #1_000_000;
                $display("FAIL global_timeout actual=running required=finished");
                $fatal(1, "bench timed out");
            end
        join_none

        vecs[0] = '{1'b1, 21'h012345, 8'h5A, 7, 8'h00};
        vecs[1] = '{1'b0, 21'h012345, 8'h00, 7, 8'h5A};
        vecs[2] = '{1'b1, 21'h000000, 8'h3C, 0, 8'h00};
        vecs[3] = '{1'b0, 21'h000000, 8'h00, 0, 8'h3C};
        vecs[4] = '{1'b1, 21'h1FFFFF, 8'hC3, 1, 8'h00};
        vecs[5] = '{1'b0, 21'h1FFFFF, 8'h00, 2, 8'hC3};
        vecs[6] = '{1'b0, 21'h0ABCDE, 8'h00, 3, 8'h7B};
        vecs[7] = '{1'b1, 21'h012345, 8'hA1, 4, 8'h00};
        vecs[8] = '{1'b0, 21'h012345, 8'h00, 0, 8'hA1};

        reset        = 1'b1;
        bus.cpu_req  = 1'b0;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_din  = '0;
        repeat (3) tick();
        chk("rst_ready", bus.cpu_ready, 0);
        chk("rst_rvalid", bus.cpu_rvalid, 0);
        chk("rst_dout", bus.cpu_dout, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_tmo", bus.tmo_err, 0);
        chk("rst_req", bus.RAM_A_REQ, 0);
        chk("rst_rdn", bus.RAM_A_RD_n, 0);
        chk("rst_addr", bus.RAM_A_ADDR, 0);
        chk("rst_di", bus.RAM_A_DI, 0);
        reset = 1'b0;
        tick();
        chk("ready_after_drain", bus.cpu_ready, 1);

        for (int i = 0; i < 9; i++) begin
            lat_fix = vecs[i].lat;
            send(vecs[i].we, vecs[i].addr, vecs[i].data);
            if (!vecs[i].we) begin
                wait_rvalid(100, n);
                chk($sformatf("vec%0d_rvalid", i), bus.cpu_rvalid, 1);
                chk($sformatf("vec%0d_dout", i), bus.cpu_dout, vecs[i].exp_dout);
                held = bus.cpu_dout;
                tick();
                chk($sformatf("vec%0d_pulse", i), bus.cpu_rvalid, 0);
                chk($sformatf("vec%0d_held", i), bus.cpu_dout, held);
            end
            wait_idle();
        end

        // Back-pressure: stalled controller, queue plus issue slot fill up
        lat_fix   = 12;
        base_done = n_done;
        acc       = 0;
        n         = 0;
        bus.cpu_req = 1'b1;
        bus.cpu_we  = 1'b1;
        while (acc < 6 && n < 500) begin
            bus.cpu_addr = AW'(21'h000100 + acc);
            bus.cpu_din  = 8'(8'h10 + acc);
            if (bus.cpu_ready) acc++;
            tick();
            n++;
            if (n == 6) begin
                chk("bp_accepts_6cyc", acc, QD + 1);
                chk("bp_ready_low", bus.cpu_ready, 0);
            end
        end
        bus.cpu_req = 1'b0;
        early = 0;
        n     = 0;
        while ((bus.busy || w_left > 0) && n < 1000) begin
            if (!bus.busy && w_left > 0) early++;
            tick();
            n++;
        end
        chk("bp_busy_early", early, 0);
        chk("bp_all_done", n_done - base_done, 6);
        chk("bp_busy_fell", bus.busy, 0);

        // Read followed at once by a write: held off until the read returns
        lat_fix = 5;
        send(1'b0, 21'h000077, 8'h00);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b1;
        bus.cpu_addr = 21'h000078;
        bus.cpu_din  = 8'h99;
        rv_idx  = -1;
        rdy_idx = -1;
        for (int c = 0; c < 200 && rdy_idx < 0; c++) begin
            if (bus.cpu_rvalid) rv_idx = c;
            if (bus.cpu_ready) rdy_idx = c;
            tick();
        end
        bus.cpu_req = 1'b0;
        chk("rw_rvalid_seen", 32'(rv_idx >= 0), 1);
        chk("rw_ready_after_rvalid", rdy_idx - rv_idx, 1);
        wait_idle();

        // Hung controller on a read
        hang = 1'b1;
        send(1'b0, 21'h0000AA, 8'h00);
        wait_req();
        chk("tmo_clear_before", bus.tmo_err, 0);
        n = 0;
        while (!bus.cpu_rvalid && n < int'(TMO) + 50) begin
            tick();
            n++;
            if (n == int'(TMO) - 4) chk("tmo_not_early", bus.tmo_err, 0);
        end
        chk("tmo_rvalid", bus.cpu_rvalid, 1);
        chk("tmo_dout", bus.cpu_dout, 8'hFF);
        chk("tmo_err_set", bus.tmo_err, 1);
        chk("tmo_latency_lo", 32'(n >= int'(TMO)), 1);
        chk("tmo_latency_hi", 32'(n <= int'(TMO) + 4), 1);
        hang = 1'b0;
        repeat (3) tick();
        chk("tmo_back_idle", bus.busy, 0);
        chk("tmo_ready", bus.cpu_ready, 1);
        lat_fix = 2;
        send(1'b1, 21'h0000AB, 8'h42);
        wait_idle();
        chk("tmo_sticky", bus.tmo_err, 1);

        // Reset two cycles after REQ while WAIT is still high
        lat_fix = 10;
        send(1'b0, 21'h000123, 8'h00);
        wait_req();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_wait_high", ram_wait, 1);
        chk("mid_rst_ready", bus.cpu_ready, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_tmo", bus.tmo_err, 0);
        n = 0;
        while (ram_wait && n < 50) begin
            chk("drain_ready", bus.cpu_ready, 0);
            tick();
            n++;
        end
        tick();
        tick();
        chk("drain_exit_ready", bus.cpu_ready, 1);

        // Random traffic over a small address window
        lat_rand = 1'b1;
        for (int i = 0; i < 150; i++) begin
            send(1'($urandom_range(0, 1)), AW'(21'h01F000 + $urandom_range(0, 7)), 8'($urandom));
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_idle();
        lat_rand = 1'b0;
        repeat (3) tick();
        chk("end_iss_empty", exp_iss.size(), 0);
        chk("end_rd_empty", exp_rd.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
